// File: rtl/imm_extend_unit.sv
// imm_extend_unit
//   Pipelined immediate-extension stage with a 2-entry skid buffer.
//   Each accepted immediate is extended by mode, then registered.
//   Results leave in the order they were accepted.
//
//   Modes:
//     00  sign-extend
//     01  zero-extend
//     10  upper-placed (low bits zero)
//     11  sign-extend, then shift left by BR_SHIFT
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   in_valid / in_ready   upstream handshake
//   in_imm, in_mode       raw immediate and extension mode
//   out_valid / out_ready downstream handshake
//   out_data              extended operand (held stable while stalled)
module imm_extend_unit #(
  parameter int IN_W     = 16,
  parameter int OUT_W    = 32,
  parameter int BR_SHIFT = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_imm,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data
);

  localparam logic [1:0] M_SIGN  = 2'b00;
  localparam logic [1:0] M_ZERO  = 2'b01;
  localparam logic [1:0] M_UPPER = 2'b10;

  // Occupancy: EMPTY = main invalid, ONE = main only, FULL = main + skid.
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;

  state_t           state_q, state_d;
  logic [OUT_W-1:0] main_q, main_d;
  logic [OUT_W-1:0] skid_q, skid_d;

  // Extension datapath.
  // The casts keep every mode legal when IN_W == OUT_W,
  // where the replicate/pad field would have zero width.
  logic [OUT_W-1:0] sext, zext, upper, ext;

  always_comb begin
    sext  = OUT_W'(signed'(in_imm));
    zext  = OUT_W'(in_imm);
    upper = zext << (OUT_W - IN_W);
    case (in_mode)
      M_SIGN:  ext = sext;
      M_ZERO:  ext = zext;
      M_UPPER: ext = upper;
      default: ext = sext << BR_SHIFT;
    endcase
  end

  logic accept, drain;
  assign accept = in_valid & in_ready;
  assign drain  = out_valid & out_ready;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= EMPTY;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY: if (accept) state_d = ONE;
      ONE: begin
        if (accept && !drain)      state_d = FULL;
        else if (!accept && drain) state_d = EMPTY;
      end
      FULL:    if (drain) state_d = ONE;
      default: state_d = EMPTY;
    endcase
  end

  // Outputs depend only on registered state.
  // This keeps out_ready off any combinational path to in_ready.
  always_comb begin
    in_ready  = (state_q != FULL);
    out_valid = (state_q == ONE) || (state_q == FULL);
  end

  // Data registers.
  // main_q only changes on a fill or a drain, so out_data holds under stall.
  always_comb begin
    main_d = main_q;
    skid_d = skid_q;
    case (state_q)
      EMPTY: if (accept) main_d = ext;
      ONE: begin
        if (accept && drain) main_d = ext;
        else if (accept)     skid_d = ext;
      end
      FULL: if (drain) begin
        main_d = skid_q;
        skid_d = '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      main_q <= main_d;
      skid_q <= skid_d;
    end
  end

  assign out_data = main_q;

endmodule
